// File: rtl/dram_load_align.sv
// Load-return stage: registers a MEM-stage load, picks and extends the addressed lane of the SRAM word.
// Latency: result valid the cycle after capture; SRAM word sampled only in that first cycle.
// Backpressure: in_ready = !out_valid || out_ready; the word is parked in a hold register while WB stalls.
module dram_load_align (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_load_op,
    input  logic [1:0]  in_addr_byte,
    input  logic [4:0]  in_dest,
    input  logic        flush,
    input  logic [31:0] data_sram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_dest,
    output logic        out_is_load,
    output logic        out_adel
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FRESH = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b111;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [4:0]  dest_q;
    logic [31:0] hold_q;

    logic        capture;
    logic        hold_load;
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_load;
    logic        adel;
    logic [31:0] data_ext;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = !out_valid || out_ready;
    // Flush beats a simultaneous capture: nothing enters on a flush edge.
    assign capture   = in_valid && in_ready && !flush;

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (capture) state_d = ST_FRESH;
                end
                ST_FRESH: begin
                    if (out_ready) begin
                        state_d = capture ? ST_FRESH : ST_EMPTY;
                    end else begin
                        state_d   = ST_HELD;
                        hold_load = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (out_ready) state_d = capture ? ST_FRESH : ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            op_q    <= 3'b000;
            off_q   <= 2'b00;
            dest_q  <= 5'd0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                op_q   <= in_load_op;
                off_q  <= in_addr_byte;
                dest_q <= in_dest;
            end
            if (hold_load) hold_q <= data_sram_rdata;
        end
    end

    // The SRAM word is only trustworthy in the first cycle after capture.
    assign word = (state_q == ST_FRESH) ? data_sram_rdata : hold_q;

    always_comb begin
        byte_sel = word[7:0];
        unique case (off_q)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    assign half_sel = off_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        is_load  = 1'b0;
        adel     = 1'b0;
        data_ext = 32'd0;
        unique case (op_q)
            OP_LB: begin
                is_load  = 1'b1;
                data_ext = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                is_load  = 1'b1;
                data_ext = {24'd0, byte_sel};
            end
            OP_LH: begin
                is_load  = 1'b1;
                adel     = off_q[0];
                data_ext = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                is_load  = 1'b1;
                adel     = off_q[0];
                data_ext = {16'd0, half_sel};
            end
            OP_LW: begin
                is_load  = 1'b1;
                adel     = (off_q != 2'd0);
                data_ext = word;
            end
            default: begin
                is_load  = 1'b0;
                adel     = 1'b0;
                data_ext = 32'd0;
            end
        endcase
    end

    assign out_data    = (out_valid && is_load && !adel) ? data_ext : 32'd0;
    assign out_is_load = out_valid && is_load;
    assign out_adel    = out_valid && adel;
    assign out_dest    = dest_q;

endmodule

// File: doc/dram_load_align.md
# dram_load_align

Load-return stage of the data-memory path: registers a load instruction leaving MEM, picks the addressed byte/halfword out of the 32-bit word that the synchronous data SRAM returns one cycle later, and sign- or zero-extends it for register write-back. It also holds that word if write-back stalls, and flags misaligned loads. It is the read-side counterpart of the store byte-enable logic: stores select lanes into the SRAM, this block selects lanes out of it. It sits between the MEM stage and the WB/register-file stage.

## Interface
- No parameters; data path fixed at 32 bits, destination index 5 bits.
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  block can accept this cycle
- in_load_op  in  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 111 lw; 101/110 treated as none
- in_addr_byte  in  2  data address bits [1:0]
- in_dest  in  5  destination register index
- flush  in  1  synchronous pipeline flush (exception/eret)
- data_sram_rdata  in  32  SRAM read word, valid only in the cycle after capture
- out_valid  out  1  result available to WB
- out_ready  in  1  WB consumes this cycle
- out_data  out  32  aligned, extended load data (0 for non-load or adel)
- out_dest  out  5  registered in_dest
- out_is_load  out  1  registered op was a legal-encoded load
- out_adel  out  1  misaligned load address error

## Operation
- Capture: in_valid && in_ready at a rising edge registers op, byte offset, dest; out_valid=1 next cycle.
- in_ready = !out_valid || out_ready (pass-through bubble collapse).
- Data-source states:
  - EMPTY: out_valid=0.
  - FRESH: first cycle after capture; out_data computed combinationally from data_sram_rdata.
  - HELD: out_data computed from internal 32-bit hold register.
- Transitions:
  - EMPTY -> FRESH on capture.
  - FRESH -> EMPTY on out_ready without capture; FRESH -> FRESH on out_ready with capture.
  - FRESH -> HELD on !out_ready, latching data_sram_rdata into the hold register.
  - HELD stays while !out_ready; on out_ready -> FRESH if capture, else EMPTY.
- Lane selection, offset b = in_addr_byte:
  - lb/lbu: byte rdata[8b+7:8b], sign- / zero-extended to 32.
  - lh/lhu: b=0 -> [15:0], b=2 -> [31:16], extended; b=1 or 3 -> adel.
  - lw: b=0 -> whole word; b≠0 -> adel.
- out_adel=1 forces out_data=0; out_is_load still 1.
- Non-load ops pass through with out_is_load=0, out_data=0, out_adel=0.
- flush: at next edge out_valid=0, state EMPTY; flush wins over a simultaneous capture (nothing captured that edge).

## Timing
- Reset values: out_valid 0, out_data 0, out_dest 0, out_is_load 0, out_adel 0, state EMPTY, hold register 0; in_ready 1 after reset.
- Latency: capture edge E0 -> result valid in cycle E0..E1, consumed at E1 if out_ready.
- Throughput: one load per cycle with out_ready held high.
- data_sram_rdata sampled only in FRESH; ignored in EMPTY/HELD, so SRAM may be re-addressed during a stall.
- out_data/out_valid/out_dest stable across any number of stall cycles in HELD.
- Async resetn mid-operation clears all state immediately; a held word is discarded.
- Simultaneous out_ready and capture: old result consumed and new op captured on the same edge, no bubble.

## Test plan
- lb, offset 3, rdata 0x80112233 -> out_data 0xFFFFFF80; lbu same -> 0x00000080; both valid one cycle after capture.
- lh offset 2, rdata 0x8001_7FFF -> 0xFFFF8001; lhu offset 0 -> 0x00007FFF; lh offset 1 -> out_adel=1, out_data 0.
- lw offset 0 captured, out_ready=0 for 3 cycles while rdata changes to 0xDEADBEEF -> out_data holds the original word 0x12345678 until out_ready; in_ready=0 during the stall.
- Back-to-back lw/lbu/lh with out_ready=1 every cycle -> three consecutive valid results, no bubbles, correct dest per result.
- flush asserted with in_valid=1 in FRESH state -> next cycle out_valid=0, no capture; resetn pulled low while HELD -> all outputs 0 immediately.
